// File: rtl/gray_morph_pkg.sv
// Shared definitions for the gray morphology filter.
// Holds the runtime mode encoding, the fixed pixel-in to pixel-out latency,
// and the 3-input min/max helpers used by the window engine.
// The helpers work on FN_W-bit operands. Callers zero-extend narrower pixels
// and truncate the result back, so DATA_W must not exceed FN_W.
package gray_morph_pkg;

  typedef enum logic [1:0] {
    MODE_BYPASS = 2'd0,
    MODE_ERODE  = 2'd1,
    MODE_DILATE = 2'd2,
    MODE_GRAD   = 2'd3
  } morph_mode_e;

  localparam int PIPE_LAT = 4;
  localparam int FN_W     = 32;

  function automatic logic [FN_W-1:0] min3(input logic [FN_W-1:0] a,
                                           input logic [FN_W-1:0] b,
                                           input logic [FN_W-1:0] c);
    logic [FN_W-1:0] m;
    m = (a < b) ? a : b;
    return (m < c) ? m : c;
  endfunction

  function automatic logic [FN_W-1:0] max3(input logic [FN_W-1:0] a,
                                           input logic [FN_W-1:0] b,
                                           input logic [FN_W-1:0] c);
    logic [FN_W-1:0] m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/gray_line_buffer.sv
// Single-port line RAM with a registered, read-before-write data port.
// Ports:
//   clk    pixel clock
//   en     port enable (read and optional write this cycle)
//   we     write enable, qualified by en
//   addr   column address
//   wdata  pixel to store
//   rdata  previous contents of addr, one cycle later
// Contents are not reset; they are always written before being used.
module gray_line_buffer #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 640,
  parameter int AW     = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              en,
  input  logic              we,
  input  logic [AW-1:0]     addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  // RAM port: old data comes out while the new pixel goes in
  always_ff @(posedge clk) begin
    if (en) begin
      rdata <= mem[addr];
      if (we) begin
        mem[addr] <= wdata;
      end
    end
  end

endmodule

// File: rtl/gray_morph_filter.sv
// 3x3 gray morphology engine: bypass, erosion (min), dilation (max) and
// morphological gradient (max-min), mode selected once per frame.
// Ports:
//   clk, rst_n                  pixel clock, async active-low reset
//   per_frame_vsync/href        input frame sync / line valid
//   per_img_Gray                input pixel
//   morph_mode                  0 bypass, 1 erode, 2 dilate, 3 gradient
//   post_frame_vsync/href       syncs delayed by PIPE_LAT cycles
//   post_img_Gray               filtered pixel, aligned with post_frame_href
// Optional build macro GRAY_MORPH_STATS_EN adds stat_nz_count / stat_valid:
// the count of nonzero output pixels per frame, published on the falling
// edge of post_frame_vsync.
module gray_morph_filter
  import gray_morph_pkg::*;
#(
  parameter int         DATA_W       = 8,
  parameter int         IMG_HDISP    = 640,
  parameter int         IMG_VDISP    = 480,
  parameter logic [1:0] MODE_DEFAULT = 2'd1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              per_frame_vsync,
  input  logic              per_frame_href,
  input  logic [DATA_W-1:0] per_img_Gray,
  input  logic [1:0]        morph_mode,
`ifdef GRAY_MORPH_STATS_EN
  output logic [$clog2(IMG_HDISP*IMG_VDISP+1)-1:0] stat_nz_count,
  output logic              stat_valid,
`endif
  output logic              post_frame_vsync,
  output logic              post_frame_href,
  output logic [DATA_W-1:0] post_img_Gray
);

  localparam int COL_W = $clog2(IMG_HDISP + 1);
  localparam int ROW_W = $clog2(IMG_VDISP);
  localparam int AW    = $clog2(IMG_HDISP);
  localparam logic [COL_W-1:0] COL_MAX = COL_W'(IMG_HDISP);
  localparam logic [ROW_W-1:0] ROW_MAX = ROW_W'(IMG_VDISP - 1);

  logic              vsync_prev_r, href_prev_r, armed_r;
  logic [COL_W-1:0]  col_r;
  logic [ROW_W-1:0]  row_r;
  morph_mode_e       mode_r;
  logic              vs_rise_s, href_fall_s, in_range_s, ok_s, we_a_s, we_b_s;
  logic [AW-1:0]     lb_addr_s;
  logic [DATA_W-1:0] rd_a_s, rd_b_s, tap_r1_s, tap_r2_s;

  assign vs_rise_s   = per_frame_vsync & ~vsync_prev_r;
  assign href_fall_s = href_prev_r & ~per_frame_href;
  assign in_range_s  = (col_r < COL_MAX);
  assign ok_s        = per_frame_href & in_range_s & (col_r >= COL_W'(2)) & (row_r >= ROW_W'(2));
  assign lb_addr_s   = in_range_s ? col_r[AW-1:0] : {AW{1'b0}};
  // Buffers alternate by row parity: the one written this row hands back row
  // r-2 (read-before-write), the other one still holds row r-1.
  assign we_a_s      = per_frame_href & in_range_s & ~row_r[0];
  assign we_b_s      = per_frame_href & in_range_s &  row_r[0];

  // Frame/line bookkeeping: edge detectors, counters, per-frame mode, armed flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // Held high so a vsync already high at reset release is not a frame start
      vsync_prev_r <= 1'b1;
      href_prev_r  <= 1'b0;
      col_r        <= {COL_W{1'b0}};
      row_r        <= {ROW_W{1'b0}};
      mode_r       <= morph_mode_e'(MODE_DEFAULT);
      armed_r      <= 1'b0;
    end else begin
      vsync_prev_r <= per_frame_vsync;
      href_prev_r  <= per_frame_href;
      if (vs_rise_s) begin
        col_r   <= {COL_W{1'b0}};
        row_r   <= {ROW_W{1'b0}};
        mode_r  <= morph_mode_e'(morph_mode);
        armed_r <= 1'b1;
      end else if (href_fall_s) begin
        col_r <= {COL_W{1'b0}};
        if (row_r != ROW_MAX) row_r <= row_r + ROW_W'(1);
      end else if (per_frame_href && (col_r != COL_MAX)) begin
        col_r <= col_r + COL_W'(1);
      end
    end
  end

  gray_line_buffer #(.DATA_W(DATA_W), .DEPTH(IMG_HDISP), .AW(AW)) u_lb_a (
    .clk(clk), .en(per_frame_href), .we(we_a_s), .addr(lb_addr_s),
    .wdata(per_img_Gray), .rdata(rd_a_s));

  gray_line_buffer #(.DATA_W(DATA_W), .DEPTH(IMG_HDISP), .AW(AW)) u_lb_b (
    .clk(clk), .en(per_frame_href), .we(we_b_s), .addr(lb_addr_s),
    .wdata(per_img_Gray), .rdata(rd_b_s));

  logic              s1_valid_r, s1_ok_r, s1_par_r;
  logic [DATA_W-1:0] s1_pix_r;
  logic              s2_valid_r, s2_ok_r, s3_valid_r, s3_ok_r;
  logic [DATA_W-1:0] win_r [3][3];   // [row: r-2,r-1,r][col: c-2,c-1,c]
  logic [DATA_W-1:0] rmin_r [3];
  logic [DATA_W-1:0] rmax_r [3];
  logic [DATA_W-1:0] ctr_r, mn_s, mx_s, morph_s;
  logic [PIPE_LAT-2:0] vs_pipe_r;

  // Map the two buffer outputs onto the r-1 / r-2 taps
  always_comb begin
    if (s1_par_r) begin
      tap_r2_s = rd_b_s;
      tap_r1_s = rd_a_s;
    end else begin
      tap_r2_s = rd_a_s;
      tap_r1_s = rd_b_s;
    end
  end

  // S1-S3 pipeline: tap alignment, window column shift, per-row min/max
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_r <= 1'b0;
      s1_ok_r    <= 1'b0;
      s1_par_r   <= 1'b0;
      s1_pix_r   <= {DATA_W{1'b0}};
      s2_valid_r <= 1'b0;
      s2_ok_r    <= 1'b0;
      s3_valid_r <= 1'b0;
      s3_ok_r    <= 1'b0;
      ctr_r      <= {DATA_W{1'b0}};
      for (int i = 0; i < 3; i++) begin
        rmin_r[i] <= {DATA_W{1'b0}};
        rmax_r[i] <= {DATA_W{1'b0}};
        for (int j = 0; j < 3; j++) win_r[i][j] <= {DATA_W{1'b0}};
      end
    end else begin
      s1_valid_r <= per_frame_href;
      s1_ok_r    <= ok_s;
      s1_par_r   <= row_r[0];
      s1_pix_r   <= per_img_Gray;
      s2_valid_r <= s1_valid_r;
      s2_ok_r    <= s1_ok_r;
      if (s1_valid_r) begin
        for (int i = 0; i < 3; i++) begin
          win_r[i][0] <= win_r[i][1];
          win_r[i][1] <= win_r[i][2];
        end
        win_r[0][2] <= tap_r2_s;
        win_r[1][2] <= tap_r1_s;
        win_r[2][2] <= s1_pix_r;
      end
      s3_valid_r <= s2_valid_r;
      s3_ok_r    <= s2_ok_r;
      ctr_r      <= win_r[1][1];
      for (int i = 0; i < 3; i++) begin
        rmin_r[i] <= DATA_W'(min3(FN_W'(win_r[i][0]), FN_W'(win_r[i][1]), FN_W'(win_r[i][2])));
        rmax_r[i] <= DATA_W'(max3(FN_W'(win_r[i][0]), FN_W'(win_r[i][1]), FN_W'(win_r[i][2])));
      end
    end
  end

  // S4 combine across rows and select the frame's mode
  always_comb begin
    mn_s = DATA_W'(min3(FN_W'(rmin_r[0]), FN_W'(rmin_r[1]), FN_W'(rmin_r[2])));
    mx_s = DATA_W'(max3(FN_W'(rmax_r[0]), FN_W'(rmax_r[1]), FN_W'(rmax_r[2])));
    case (mode_r)
      MODE_BYPASS: morph_s = ctr_r;
      MODE_ERODE:  morph_s = mn_s;
      MODE_DILATE: morph_s = mx_s;
      MODE_GRAD:   morph_s = mx_s - mn_s;   // max >= min, never wraps
      default:     morph_s = ctr_r;
    endcase
  end

  // S4 output registers; unarmed or border positions emit zero
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vs_pipe_r        <= {(PIPE_LAT-1){1'b0}};
      post_frame_vsync <= 1'b0;
      post_frame_href  <= 1'b0;
      post_img_Gray    <= {DATA_W{1'b0}};
    end else begin
      vs_pipe_r        <= {vs_pipe_r[PIPE_LAT-3:0], per_frame_vsync};
      post_frame_vsync <= vs_pipe_r[PIPE_LAT-2];
      post_frame_href  <= s3_valid_r & armed_r;
      post_img_Gray    <= (s3_valid_r & s3_ok_r & armed_r) ? morph_s : {DATA_W{1'b0}};
    end
  end

`ifdef GRAY_MORPH_STATS_EN
  localparam int STAT_W = $clog2(IMG_HDISP*IMG_VDISP+1);
  logic [STAT_W-1:0] nz_cnt_r;
  logic              post_vs_prev_r, nz_hit_s;

  assign nz_hit_s = post_frame_href & (post_img_Gray != {DATA_W{1'b0}});

  // Nonzero-pixel counter, published and cleared on output vsync fall
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      nz_cnt_r       <= {STAT_W{1'b0}};
      post_vs_prev_r <= 1'b0;
      stat_nz_count  <= {STAT_W{1'b0}};
      stat_valid     <= 1'b0;
    end else begin
      post_vs_prev_r <= post_frame_vsync;
      if (post_vs_prev_r && !post_frame_vsync) begin
        stat_nz_count <= nz_cnt_r;
        stat_valid    <= 1'b1;
        nz_cnt_r      <= nz_hit_s ? STAT_W'(1) : {STAT_W{1'b0}};
      end else begin
        stat_valid <= 1'b0;
        if (nz_hit_s) nz_cnt_r <= nz_cnt_r + STAT_W'(1);
      end
    end
  end
`endif

endmodule

// File: tb/tb_gray_morph_filter.sv
module tb_gray_morph_filter;

  localparam int DW = 8;
  localparam int HD = 10;
  localparam int VD = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          vs = 1'b0;
  logic          hr = 1'b0;
  logic [DW-1:0] pix = '0;
  logic [1:0]    mode_in = 2'd1;
  logic          post_vs, post_hr;
  logic [DW-1:0] post_pix;
`ifdef GRAY_MORPH_STATS_EN
  localparam int SW = $clog2(HD*VD+1);
  logic [SW-1:0] st_cnt;
  logic          st_valid;
`endif

  gray_morph_filter #(.DATA_W(DW), .IMG_HDISP(HD), .IMG_VDISP(VD), .MODE_DEFAULT(2'd1)) dut (
    .clk(clk), .rst_n(rst_n),
    .per_frame_vsync(vs), .per_frame_href(hr), .per_img_Gray(pix), .morph_mode(mode_in),
`ifdef GRAY_MORPH_STATS_EN
    .stat_nz_count(st_cnt), .stat_valid(st_valid),
`endif
    .post_frame_vsync(post_vs), .post_frame_href(post_hr), .post_img_Gray(post_pix));

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {int val; int at; int r; int c;} exp_t;
  exp_t q[$];
  exp_t mon_e;
  int   img[16][16];
  int   lw[16];
  int   armed_m = 0;
  int   frame_mode = 1;
  int   href_seen = 0;
  int   href_at_rst = 0;
  int   vs_hold = 8;
  bit   vs_log[16];
  int   checks = 0;
  int   failures = 0;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Reference: window centred on input (r-1,c-1), zero on the borders
  function automatic int ref_px(input int r, input int c);
    int mn, mx;
    mn = 255; mx = 0;
    if (r < 2 || c < 2 || c >= HD) return 0;
    for (int dr = 0; dr < 3; dr++)
      for (int dc = 0; dc < 3; dc++) begin
        if (img[r-2+dr][c-2+dc] < mn) mn = img[r-2+dr][c-2+dc];
        if (img[r-2+dr][c-2+dc] > mx) mx = img[r-2+dr][c-2+dc];
      end
    case (frame_mode)
      0: return img[r-1][c-1];
      1: return mn;
      2: return mx;
      default: return mx - mn;
    endcase
  endfunction

  // Monitor: vsync alignment every cycle, scoreboard pop on every output pixel
  always @(negedge clk) begin
    vs_log[cyc % 16] = vs;
    if (rst_n) begin
      if (vs_hold > 0) vs_hold--;
      else chk("vsync_align", int'(post_vs), int'(vs_log[(cyc + 12) % 16]));
      if (post_hr) begin
        href_seen++;
        if (q.size() == 0) chk("unexpected_href", 1, 0);
        else begin
          mon_e = q.pop_front();
          chk($sformatf("pix_r%0d_c%0d", mon_e.r, mon_e.c), int'(post_pix), mon_e.val);
          chk($sformatf("lat_r%0d_c%0d", mon_e.r, mon_e.c), cyc, mon_e.at);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    q.delete();
    armed_m = 0;
    vs_hold = 6;
    tick();
    tick();
    rst_n = 1'b1;
    href_at_rst = href_seen;
  endtask

  task automatic fill(input int h, input int w, input int val, input bit rnd);
    for (int r = 0; r < 16; r++) begin
      lw[r] = (r < h) ? w : 0;
      for (int c = 0; c < 16; c++) img[r][c] = rnd ? int'($urandom_range(255, 0)) : val;
    end
  endtask

  task automatic send_frame(input int h, input int m, input bit rise,
                            input int tog_row, input int tog_mode, input int rst_row);
    exp_t e;
`ifdef GRAY_MORPH_STATS_EN
    int nz; int t0; bit got;
    nz = 0;
`endif
    if (rise) begin
      vs = 1'b1; mode_in = 2'(m); tick();
      armed_m = 1; frame_mode = m; tick();
    end
    for (int r = 0; r < h; r++) begin
      if (r == rst_row) do_reset();
      if (r == tog_row) mode_in = 2'(tog_mode);
      for (int c = 0; c < lw[r]; c++) begin
        hr = 1'b1; pix = DW'(img[r][c]);
        if (armed_m != 0) begin
          e.val = ref_px(r, c); e.at = cyc + 4; e.r = r; e.c = c;
          q.push_back(e);
`ifdef GRAY_MORPH_STATS_EN
          if (e.val != 0) nz++;
`endif
        end
        tick();
      end
      hr = 1'b0;
      repeat (3) tick();
    end
    repeat (2) tick();
    if (rise) begin
      vs = 1'b0;
`ifdef GRAY_MORPH_STATS_EN
      t0 = cyc;
      if (armed_m != 0) begin
        got = 1'b0;
        for (int k = 0; k < 20 && !got; k++) begin
          @(negedge clk);
          if (st_valid) begin
            got = 1'b1;
            chk("stat_valid_cycle", cyc, t0 + 5);
            chk("stat_nz_count", int'(st_cnt), nz);
          end
          @(posedge clk); #1;
        end
        if (!got) chk("stat_valid_timeout", 0, 1);
      end
`endif
    end
    repeat (8) tick();
    chk("drain", q.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    int h0, m, h, w;
    repeat (2) tick();
    @(negedge clk);
    chk("reset_vsync", int'(post_vs), 0);
    chk("reset_href", int'(post_hr), 0);
    chk("reset_pix", int'(post_pix), 0);
`ifdef GRAY_MORPH_STATS_EN
    chk("reset_stat_cnt", int'(st_cnt), 0);
    chk("reset_stat_valid", int'(st_valid), 0);
`endif
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (3) tick();

    // Frame with no vsync rise since reset: nothing may come out
    fill(4, 6, 0, 1'b1);
    h0 = href_seen;
    send_frame(4, 1, 1'b0, -1, 0, -1);
    chk("unarmed_href_count", href_seen - h0, 0);

    // Single dark pixel, erode
    fill(8, 8, 100, 1'b0);
    img[3][3] = 0;
    send_frame(8, 1, 1'b1, -1, 0, -1);

    // Single bright pixel, dilate then gradient
    img[3][3] = 255;
    send_frame(8, 2, 1'b1, -1, 0, -1);
    send_frame(8, 3, 1'b1, -1, 0, -1);

    // Mode change mid-frame only takes effect on the next frame
    fill(8, 8, 0, 1'b1);
    send_frame(8, 1, 1'b1, 3, 2, -1);
    send_frame(8, 2, 1'b1, -1, 0, -1);

    // Over-long line: extra pixels read 0, later rows unaffected
    fill(6, HD, 0, 1'b1);
    lw[3] = HD + 3;
    send_frame(6, 2, 1'b1, -1, 0, -1);
    send_frame(6, 0, 1'b1, -1, 0, -1);

    // Reset mid-frame: rest of the frame silent, next frame recovers
    fill(6, 8, 0, 1'b1);
    send_frame(6, 3, 1'b1, -1, 0, 3);
    chk("no_href_after_reset", href_seen - href_at_rst, 0);
    send_frame(6, 1, 1'b1, -1, 0, -1);

    // Randomised frames
    for (int n = 0; n < 5; n++) begin
      m = int'($urandom_range(3, 0));
      h = int'($urandom_range(VD, 3));
      w = int'($urandom_range(HD, 3));
      fill(h, w, 0, 1'b1);
      send_frame(h, m, 1'b1, -1, 0, -1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/gray_morph_filter.md
Name: gray_morph_filter

Overview:
- Parametrised successor to the fixed gray erosion/dilation stages of the video image processor chain.
- One 3x3 window engine with generic pixel width and a per-frame runtime mode: bypass, erosion (min), dilation (max), morphological gradient (max-min).
- Sits after the Sobel stage on the gray stream. Uses the same vsync/href/pixel video interface on input and output.

Parameters:
- DATA_W, 8, gray pixel width in bits.
- IMG_HDISP, 640, active pixels per line; sets line-buffer depth.
- IMG_VDISP, 480, active lines per frame; sets the row-counter saturation limit.
- MODE_DEFAULT, 2'd1, mode loaded at reset (erosion).

Ports:
- clk  in  1  pixel clock.
- rst_n  in  1  asynchronous active-low reset.
- per_frame_vsync  in  1  input frame sync, active high.
- per_frame_href  in  1  input line valid, active high.
- per_img_Gray  in  DATA_W  input pixel, valid when per_frame_href=1.
- morph_mode  in  2  0 bypass, 1 erode, 2 dilate, 3 gradient.
- post_frame_vsync  out  1  vsync delayed 4 cycles.
- post_frame_href  out  1  href delayed 4 cycles, gated by the armed flag.
- post_img_Gray  out  DATA_W  filtered pixel.

Behaviour:
- Reset: all outputs 0; counters 0; window 0; mode_q=MODE_DEFAULT; armed=0. Line-buffer contents are don't-care.
- Frame-start edge (per_frame_vsync 0->1):
  - mode_q<=morph_mode. Mode is never changed mid-frame.
  - row counter<=0; armed<=1.
- armed=0 (after reset until the first vsync rise): post_frame_href and post_img_Gray are held 0; vsync is still delayed and passed.
- Column counter: increments per valid pixel; clears when href falls.
- Row counter: increments when href falls; saturates at IMG_VDISP-1.
- Pixels beyond column IMG_HDISP-1:
  - No line-buffer write; the counter saturates.
  - Output is border value 0.
- Line buffers: two single-port RAMs, depth IMG_HDISP, width DATA_W, read-before-write at address=column counter. They form the rows r-1 and r-2 taps.
- Pipeline, fixed latency 4 cycles pixel-in to pixel-out:
  - S1: line-buffer read and write.
  - S2: 3x3 window column shift.
  - S3: per-row 3-input min and max.
  - S4: combine across rows, then the mode mux.
- Spatial registration: the output pixel at (r,c) is the window centred on input (r-1,c-1).
  - If r<2 or c<2: output 0.
  - Bypass mode outputs the centre pixel, same registration.
- Gradient: max-min, DATA_W bits, never negative, no saturation needed.
- post_frame_href and post_frame_vsync are 4-stage shift registers. Pixel and sync stay exactly aligned for every mode.
- Gaps between pixels inside a line (href low mid-line): treated as end of line.
- Reset asserted mid-frame: immediate clear. The remainder of the frame produces no output href until the next vsync rise.
- vsync rise while href=1 (malformed): the counters restart; the line in flight is discarded via the row counter reset.

Optional Feature:
- Macro GRAY_MORPH_STATS_EN.
- When defined:
  - Adds output stat_nz_count (width $clog2(IMG_HDISP*IMG_VDISP+1)).
  - Adds output stat_valid (1-bit pulse).
  - Counts output pixels with post_frame_href=1 and post_img_Gray!=0.
  - On post_frame_vsync falling edge: count is latched to stat_nz_count, stat_valid pulses for 1 cycle, and the internal counter clears.
  - Reset values are 0.
- When undefined: these ports and that logic are absent. Behaviour is otherwise identical.

Decomposition:
- Package gray_morph_pkg holds:
  - the mode enum (MODE_BYPASS, MODE_ERODE, MODE_DILATE, MODE_GRAD);
  - the PIPE_LAT=4 constant;
  - a min3/max3 function pair.
- Sub-module gray_line_buffer: one RAM of depth IMG_HDISP with a registered read, instantiated twice.

Test Plan:
- Reset then a 6x4 frame in erode mode without a prior vsync rise -> post_frame_href stays 0 throughout.
- 8x8 frame, all pixels 100, one pixel at input (3,3)=0, mode 1 -> output positions (3..5,3..5) read 0, others with r,c>=2 read 100, r<2 or c<2 read 0.
- Same frame with mode 2 and the single pixel set to 255 -> a 3x3 block of 255 at output (3..5,3..5). Mode 3 -> gradient 155 in that block, 0 elsewhere.
- morph_mode toggled 1->2 mid-frame -> the current frame stays erode; the next frame after the vsync rise is dilate.
- Line of IMG_HDISP+3 pixels -> the last 3 outputs are 0, and the next row's window taps are unaffected.
- With GRAY_MORPH_STATS_EN, dilate frame from the test above -> stat_nz_count equals the number of nonzero output pixels in that frame; stat_valid is high 1 cycle after post_frame_vsync falls.
